// File: rtl/bp_mem_responder.sv
// On-chip block-addressed RAM answering CCE memory commands one at a time,
// with a fixed programmable delay between command accept and response valid.
module bp_mem_responder #(
  parameter int paddr_width_p      = 40,
  parameter int cce_block_width_p  = 512,
  parameter int lce_id_width_p     = 4,
  parameter int lce_assoc_p        = 8,
  parameter int mem_els_p          = 1024,
  parameter int latency_p          = 2,
  localparam int way_id_width_lp   = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  localparam int cce_mem_msg_width_lp = 4 + paddr_width_p + 3 + lce_id_width_p
                                      + way_id_width_lp + cce_block_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_yumi_i
);

  localparam int block_bytes_lp  = cce_block_width_p / 8;
  localparam int offset_width_lp = $clog2(block_bytes_lp);
  localparam int index_width_lp  = $clog2(mem_els_p);

  localparam logic [3:0] e_cce_mem_rd    = 4'd0;
  localparam logic [3:0] e_cce_mem_wr    = 4'd1;
  localparam logic [3:0] e_cce_mem_uc_rd = 4'd2;
  localparam logic [3:0] e_cce_mem_uc_wr = 4'd3;

  typedef struct packed {
    logic [3:0]                  msg_type;
    logic [paddr_width_p-1:0]    addr;
    logic [2:0]                  size;
    logic [lce_id_width_p-1:0]   lce_id;
    logic [way_id_width_lp-1:0]  way_id;
  } mem_hdr_s;

  typedef struct packed {
    mem_hdr_s                       header;
    logic [cce_block_width_p-1:0]   data;
  } mem_msg_s;

  typedef enum logic [1:0] {
    e_ready,
    e_wait,
    e_resp
  } state_e;

  mem_msg_s cmd;
  assign cmd = mem_cmd_i;

  logic [cce_block_width_p-1:0] mem_q [mem_els_p];

  state_e                          state_q, state_d;
  logic [7:0]                      cnt_q, cnt_d;
  logic                            ready_q, ready_d;
  logic                            resp_v_q, resp_v_d;
  logic [cce_mem_msg_width_lp-1:0] resp_q, resp_d;

  logic [index_width_lp-1:0]    index;
  logic [offset_width_lp-1:0]   byte_off;
  logic [31:0]                  size_bytes;
  logic [cce_block_width_p-1:0] blk_rd;
  logic [cce_block_width_p-1:0] uc_rd_data;
  logic [cce_block_width_p-1:0] uc_wr_block;
  logic [cce_block_width_p-1:0] rd_data;
  logic [cce_block_width_p-1:0] ram_wdata;
  logic                         ram_we;
  logic                         accept;
  logic [offset_width_lp-1:0]   src;
  logic [offset_width_lp-1:0]   rel;

  assign index      = cmd.header.addr[offset_width_lp +: index_width_lp];
  assign byte_off   = cmd.header.addr[offset_width_lp-1:0];
  assign size_bytes = 32'(1) << cmd.header.size;
  assign blk_rd     = mem_q[index];
  assign accept     = mem_cmd_v_i & ready_q;

  // Uncached access: byte lanes wrap modulo the block, so misaligned
  // accesses stay within the addressed block.
  always_comb begin
    uc_rd_data  = '0;
    uc_wr_block = blk_rd;
    src         = '0;
    rel         = '0;
    for (int j = 0; j < block_bytes_lp; j++) begin
      src = byte_off + offset_width_lp'(j);
      if (32'(j) < size_bytes) begin
        uc_rd_data[8*j +: 8] = blk_rd[{src, 3'b000} +: 8];
      end
      rel = offset_width_lp'(j) - byte_off;
      if (32'(rel) < size_bytes) begin
        uc_wr_block[8*j +: 8] = cmd.data[{rel, 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    rd_data   = '0;
    ram_wdata = uc_wr_block;
    ram_we    = 1'b0;
    case (cmd.header.msg_type)
      e_cce_mem_rd:    rd_data = blk_rd;
      e_cce_mem_uc_rd: rd_data = uc_rd_data;
      e_cce_mem_wr: begin
        ram_we    = accept;
        ram_wdata = cmd.data;
      end
      e_cce_mem_uc_wr: ram_we = accept;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      mem_q[index] <= ram_wdata;
    end
  end

  // The response is captured whole at accept, so it stays stable while
  // the consumer stalls; the counter only paces when it becomes visible.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    resp_v_d = resp_v_q;
    resp_d   = resp_q;
    case (state_q)
      e_ready: begin
        if (accept) begin
          ready_d = 1'b0;
          resp_d  = {cmd.header, rd_data};
          if (latency_p == 0) begin
            state_d  = e_resp;
            resp_v_d = 1'b1;
          end else begin
            state_d = e_wait;
            cnt_d   = 8'(latency_p);
          end
        end
      end
      e_wait: begin
        if (cnt_q <= 8'd1) begin
          state_d  = e_resp;
          cnt_d    = '0;
          resp_v_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      e_resp: begin
        if (mem_resp_yumi_i) begin
          state_d  = e_ready;
          resp_v_d = 1'b0;
          ready_d  = 1'b1;
        end
      end
      default: begin
        state_d  = e_ready;
        ready_d  = 1'b1;
        resp_v_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_ready;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      resp_v_q <= 1'b0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      resp_v_q <= resp_v_d;
      resp_q   <= resp_d;
    end
  end

  // Gated by reset so ready is low while held and high right after release.
  assign mem_cmd_ready_o = ready_q & reset_n_i;
  assign mem_resp_v_o    = resp_v_q;
  assign mem_resp_o      = resp_q;

  yumi_only_when_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) mem_resp_yumi_i |-> mem_resp_v_o
  );

endmodule

// File: tb/tb_bp_mem_responder.sv
// Randomized bench for bp_mem_responder: two instances (latency 5 and 0)
// checked against a byte-array memory model.
module tb_bp_mem_responder;

  localparam int BW    = 512;
  localparam int NB    = BW / 8;
  localparam int ELS   = 16;
  localparam int MW    = 4 + 40 + 3 + 4 + 3 + BW;
  localparam int LAT_A = 5;
  localparam int LAT_B = 0;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic [MW-1:0] cmd;
  logic          vA, vB, yumiA, yumiB;
  logic          readyA, readyB, respVA, respVB;
  logic [MW-1:0] respA, respB;

  int nCompared   = 0;
  int nMismatched = 0;
  int sel = 0;

  logic [7:0] refMem [2][ELS][NB];

  always #5 clk = ~clk;

  bp_mem_responder #(.mem_els_p(ELS), .latency_p(LAT_A)) dutA (
    .clk_i(clk), .reset_n_i(rstN),
    .mem_cmd_i(cmd), .mem_cmd_v_i(vA), .mem_cmd_ready_o(readyA),
    .mem_resp_o(respA), .mem_resp_v_o(respVA), .mem_resp_yumi_i(yumiA)
  );

  bp_mem_responder #(.mem_els_p(ELS), .latency_p(LAT_B)) dutB (
    .clk_i(clk), .reset_n_i(rstN),
    .mem_cmd_i(cmd), .mem_cmd_v_i(vB), .mem_cmd_ready_o(readyB),
    .mem_resp_o(respB), .mem_resp_v_o(respVB), .mem_resp_yumi_i(yumiB)
  );

  function automatic logic curReady();
    return (sel != 0) ? readyB : readyA;
  endfunction

  function automatic logic curRespV();
    return (sel != 0) ? respVB : respVA;
  endfunction

  function automatic logic [MW-1:0] curResp();
    return (sel != 0) ? respB : respA;
  endfunction

  task automatic checkOutput(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] mkMsg(input logic [3:0] t, input logic [39:0] a,
                                          input logic [2:0] sz, input logic [3:0] lce,
                                          input logic [2:0] way, input logic [BW-1:0] d);
    return {t, a, sz, lce, way, d};
  endfunction

  function automatic logic [BW-1:0] randBlock();
    logic [BW-1:0] r;
    for (int i = 0; i < BW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Reference memory: a block is NB bytes; uncached accesses touch
  // bytes (off+k) mod NB for k < 2**size. Writes respond with zero data.
  task automatic modelApply(input int s, input logic [MW-1:0] m, output logic [MW-1:0] expResp);
    logic [3:0]    t;
    logic [39:0]   a;
    logic [BW-1:0] d, data;
    int idx, off, nBytes;
    t      = m[MW-1 -: 4];
    a      = m[MW-5 -: 40];
    nBytes = 1 << m[MW-45 -: 3];
    d      = m[BW-1:0];
    idx    = int'(a[9:6]);
    off    = int'(a[5:0]);
    data   = '0;
    case (t)
      4'd0: for (int k = 0; k < NB; k++) data[8*k +: 8] = refMem[s][idx][k];
      4'd1: for (int k = 0; k < NB; k++) refMem[s][idx][k] = d[8*k +: 8];
      4'd2: for (int k = 0; k < nBytes; k++) data[8*k +: 8] = refMem[s][idx][(off + k) % NB];
      4'd3: for (int k = 0; k < nBytes; k++) refMem[s][idx][(off + k) % NB] = d[8*k +: 8];
      default: ;
    endcase
    expResp = {m[MW-1:BW], data};
  endtask

  // One full transaction on instance s; the response is held for 'hold'
  // cycles before yumi to exercise back-pressure.
  task automatic applyStimulus(input int s, input logic [MW-1:0] m, input int hold,
                               output logic [MW-1:0] got);
    logic [MW-1:0] expResp, snap;
    int cnt, lat;
    sel = s;
    lat = (s != 0) ? LAT_B : LAT_A;
    cnt = 0;
    while (!curReady() && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("cmdReady", MW'(curReady()), MW'(1));
    cmd = m;
    if (s == 0) vA = 1'b1; else vB = 1'b1;
    @(posedge clk);
    modelApply(s, m, expResp);
    #1;
    vA = 1'b0;
    vB = 1'b0;
    @(negedge clk);
    cnt = 1;
    checkOutput("busyReady", MW'(curReady()), MW'(0));
    while (!curRespV() && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("latency", MW'(cnt), MW'(lat + 1));
    snap = curResp();
    checkOutput("resp", snap, expResp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("holdResp", curResp(), snap);
      checkOutput("holdReady", MW'(curReady()), MW'(0));
      checkOutput("holdValid", MW'(curRespV()), MW'(1));
    end
    if (s == 0) yumiA = 1'b1; else yumiB = 1'b1;
    @(posedge clk);
    #1;
    yumiA = 1'b0;
    yumiB = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterYumi", MW'(curReady()), MW'(1));
    checkOutput("validAfterYumi", MW'(curRespV()), MW'(0));
    got = snap;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [MW-1:0] got;
    logic [BW-1:0] patA, d;
    logic [39:0]   base, a;
    logic [3:0]    t;
    logic [2:0]    sz;
    int            r, s, sawResp;

    cmd = '0; vA = 1'b0; vB = 1'b0; yumiA = 1'b0; yumiB = 1'b0;
    #1 rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstReadyA", MW'(readyA), MW'(0));
    checkOutput("rstReadyB", MW'(readyB), MW'(0));
    checkOutput("rstValidA", MW'(respVA), MW'(0));
    checkOutput("rstRespA", respA, '0);
    rstN = 1'b1;
    #1;
    checkOutput("releaseReadyA", MW'(readyA), MW'(1));

    // Fill every block of both RAMs so later reads have defined contents.
    for (int si = 0; si < 2; si++)
      for (int i = 0; i < ELS; i++)
        applyStimulus(si, mkMsg(4'd1, 40'(i) << 6, 3'd6, 4'(i), 3'(i), randBlock()), 0, got);

    base = 40'h00_8000_0040;
    patA = randBlock();
    applyStimulus(0, mkMsg(4'd1, base, 3'd6, 4'hA, 3'd5, patA), 0, got);
    applyStimulus(0, mkMsg(4'd0, base, 3'd6, 4'h3, 3'd2, '0), 1, got);
    checkOutput("blockRdData", MW'(got[BW-1:0]), MW'(patA));
    checkOutput("blockRdLceId", MW'(got[BW+6:BW+3]), MW'(4'h3));

    applyStimulus(0, mkMsg(4'd3, base + 40'h8, 3'd2, 4'h1, 3'd1, BW'(32'hDEADBEEF)), 0, got);
    applyStimulus(0, mkMsg(4'd2, base + 40'h8, 3'd3, 4'h1, 3'd1, '0), 0, got);
    checkOutput("ucRdLow", MW'(got[31:0]), MW'(32'hDEADBEEF));
    checkOutput("ucRdHigh", MW'(got[63:32]), MW'(patA[127:96]));
    checkOutput("ucRdZeroExt", MW'(got[BW-1:64]), MW'(0));

    applyStimulus(0, mkMsg(4'd0, base, 3'd6, 4'h7, 3'd7, '0), 10, got);

    d = randBlock();
    applyStimulus(0, mkMsg(4'd1, 40'(ELS + 3) << 6, 3'd6, 4'h2, 3'd0, d), 0, got);
    applyStimulus(0, mkMsg(4'd0, 40'(3) << 6, 3'd6, 4'h2, 3'd0, '0), 0, got);
    checkOutput("aliasData", MW'(got[BW-1:0]), MW'(d));

    applyStimulus(1, mkMsg(4'd9, 40'h12_3456_789A, 3'd1, 4'h5, 3'd3, randBlock()), 2, got);

    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 9);
      s  = $urandom_range(0, 1);
      a  = 40'({$urandom, $urandom});
      sz = 3'($urandom_range(0, 3));
      if (r < 2)      begin t = 4'd0; sz = 3'd6; end
      else if (r < 4) begin t = 4'd1; sz = 3'd6; end
      else if (r < 6) t = 4'd2;
      else if (r < 8) t = 4'd3;
      else            t = 4'($urandom_range(4, 15));
      applyStimulus(s, mkMsg(t, a, sz, 4'($urandom), 3'($urandom), randBlock()),
                    $urandom_range(0, 3), got);
    end

    // Reset while the request sits in the delay stage: it must vanish.
    sel = 0;
    cmd = mkMsg(4'd2, base, 3'd3, 4'h4, 3'd4, '0);
    vA  = 1'b1;
    @(posedge clk);
    #1 vA = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("midRstValid", MW'(respVA), MW'(0));
    checkOutput("midRstReady", MW'(readyA), MW'(0));
    checkOutput("midRstResp", respA, '0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("postRstReady", MW'(readyA), MW'(1));
    sawResp = 0;
    repeat (12) begin
      @(negedge clk);
      if (respVA) sawResp = 1;
    end
    checkOutput("noStaleResp", MW'(sawResp), MW'(0));

    applyStimulus(0, mkMsg(4'd0, base, 3'd6, 4'h6, 3'd6, '0), 0, got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
